// File: rtl/alarm_sequencer.sv
// Alarm beep pattern sequencer: groups of beeps separated by pauses, driving the
// tone generator's enable and phase-reset inputs.
module alarm_sequencer #(
    parameter int unsigned ON_CYCLES    = 25_000_000,
    parameter int unsigned OFF_CYCLES   = 12_500_000,
    parameter int unsigned PAUSE_CYCLES = 50_000_000,
    parameter int unsigned NUM_BEEPS    = 3,
    parameter int unsigned NUM_ROUNDS   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic expired,
    input  logic stop,
    output logic tone_en,
    output logic tone_rst,
    output logic alarm_active,
    output logic done
);

    localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES)
        ? ((ON_CYCLES > PAUSE_CYCLES) ? ON_CYCLES : PAUSE_CYCLES)
        : ((OFF_CYCLES > PAUSE_CYCLES) ? OFF_CYCLES : PAUSE_CYCLES);
    localparam int unsigned TW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned BW = (NUM_BEEPS > 1) ? $clog2(NUM_BEEPS) : 1;
    localparam int unsigned RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;

    localparam logic [TW-1:0] ON_LAST    = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST   = TW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0] PAUSE_LAST = TW'(PAUSE_CYCLES - 1);
    localparam logic [BW-1:0] BEEP_LAST  = BW'(NUM_BEEPS - 1);
    localparam logic [RW-1:0] ROUND_LAST = RW'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_PAUSE
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [BW-1:0] beep_idx;
    logic [RW-1:0] round_idx;

    // Outputs are registered alongside the state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            timer        <= '0;
            beep_idx     <= '0;
            round_idx    <= '0;
            tone_en      <= 1'b0;
            tone_rst     <= 1'b0;
            alarm_active <= 1'b0;
            done         <= 1'b0;
        end else begin
            tone_rst <= 1'b0;
            done     <= 1'b0;
            if (state != S_IDLE && stop) begin
                // Abort wins over any terminal count in the same cycle.
                state        <= S_IDLE;
                timer        <= '0;
                tone_en      <= 1'b0;
                alarm_active <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (expired && !stop) begin
                            state        <= S_ON;
                            timer        <= '0;
                            beep_idx     <= '0;
                            round_idx    <= '0;
                            tone_en      <= 1'b1;
                            tone_rst     <= 1'b1;
                            alarm_active <= 1'b1;
                        end
                    end
                    S_ON: begin
                        if (timer == ON_LAST) begin
                            timer   <= '0;
                            tone_en <= 1'b0;
                            if (beep_idx < BEEP_LAST) begin
                                state <= S_OFF;
                            end else if (round_idx < ROUND_LAST) begin
                                state <= S_PAUSE;
                            end else begin
                                state        <= S_IDLE;
                                done         <= 1'b1;
                                alarm_active <= 1'b0;
                            end
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    S_OFF: begin
                        if (timer == OFF_LAST) begin
                            state    <= S_ON;
                            timer    <= '0;
                            beep_idx <= beep_idx + BW'(1);
                            tone_en  <= 1'b1;
                            tone_rst <= 1'b1;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    S_PAUSE: begin
                        if (timer == PAUSE_LAST) begin
                            state     <= S_ON;
                            timer     <= '0;
                            beep_idx  <= '0;
                            round_idx <= round_idx + RW'(1);
                            tone_en   <= 1'b1;
                            tone_rst  <= 1'b1;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

Generates the audible alarm pattern when the egg-timer countdown expires. It sits directly upstream of the square-wave tone generator and drives that generator's `enable` and `reset` inputs. The result is a repeating pattern: a group of beeps, then a pause, repeated for a fixed number of rounds or until the user presses stop. All timing is counted in system-clock cycles; the block carries no audio data itself.

## Interface
- `ON_CYCLES`, default 25_000_000: cycles the tone is enabled per beep (≥1).
- `OFF_CYCLES`, default 12_500_000: silent gap between beeps within a round (≥1).
- `PAUSE_CYCLES`, default 50_000_000: silent gap between rounds (≥1).
- `NUM_BEEPS`, default 3: beeps per round (≥1).
- `NUM_ROUNDS`, default 4: rounds per alarm (≥1).

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `expired`  in  1  countdown reached zero; a level or a pulse, sampled only in IDLE.
- `stop`  in  1  debounced user acknowledge; aborts the alarm.
- `tone_en`  out  1  connects to the tone generator's `enable`.
- `tone_rst`  out  1  connects to the tone generator's `reset`; a 1-cycle pulse at the start of each beep.
- `alarm_active`  out  1  high in every state except IDLE.
- `done`  out  1  1-cycle pulse when the pattern completes naturally.

## Operation
- States: IDLE, ON, OFF, PAUSE. Registers:
  - `timer`: width `$clog2(max(ON,OFF,PAUSE)_CYCLES)`.
  - `beep_idx`: 0..NUM_BEEPS-1.
  - `round_idx`: 0..NUM_ROUNDS-1.
- All outputs are registered. They are decoded so that each output is valid in the cycle after the edge that enters the corresponding state.
- `reset`: applies on the next edge to state IDLE, `timer` = 0, `beep_idx` = 0, `round_idx` = 0. The outputs `tone_en`, `tone_rst`, `alarm_active` and `done` are all 0. `reset` has priority over every other input.
- IDLE:
  - `expired` high and `stop` low → go to ON, clear `timer`, `beep_idx` and `round_idx`, and assert `tone_rst` for that one cycle.
  - `expired` and `stop` both high → remain in IDLE.
- ON (`tone_en` = 1), on `timer` == ON_CYCLES-1:
  - If `beep_idx` < NUM_BEEPS-1 → go to OFF.
  - Else if `round_idx` < NUM_ROUNDS-1 → go to PAUSE.
  - Else → go to IDLE with `done` = 1 for one cycle.
- OFF (`tone_en` = 0), on `timer` == OFF_CYCLES-1 → go to ON, `beep_idx`+1, pulse `tone_rst`.
- PAUSE (`tone_en` = 0), on `timer` == PAUSE_CYCLES-1 → go to ON, `beep_idx` = 0, `round_idx`+1, pulse `tone_rst`.
- `timer` is cleared on every state change and incremented otherwise. It never wraps, because the terminal compare always forces a state change.
- `stop` high in ON, OFF or PAUSE → IDLE on the next edge, `tone_en` = 0, no `done` pulse.
  - `stop` has priority over a simultaneous terminal count.
- `expired` is ignored outside IDLE. It never restarts an alarm that is running.
- If `expired` is still high when the pattern returns to IDLE, a new alarm starts on the following edge. The upstream timer is responsible for clearing `expired`.
- `tone_rst` is asserted concurrently with the first `tone_en` cycle of each beep. This restarts the tone generator's divider so every beep starts at the same phase.

## Timing
- Latency from `expired` sampled on edge E to `tone_en` = 1: visible after E (1 cycle).
- Each beep holds `tone_en` high for exactly ON_CYCLES cycles.
- Gaps are exactly OFF_CYCLES (within a round) or PAUSE_CYCLES (between rounds).
- `alarm_active` rises with the first `tone_en` and falls in the cycle after the last ON cycle, the same cycle as `done`.
- Total active length = NUM_ROUNDS·(NUM_BEEPS·ON + (NUM_BEEPS-1)·OFF) + (NUM_ROUNDS-1)·PAUSE cycles.
- `stop` latency: outputs are low 1 cycle after `stop` is sampled.

## Test plan
Benches use ON=4, OFF=2, PAUSE=6, NUM_BEEPS=2, NUM_ROUNDS=2.
- **Reset:** assert `reset` for 3 cycles with `expired` = 1 → all outputs 0 and state IDLE throughout; the alarm starts on the first edge after `reset` drops.
- **Full pattern:** 1-cycle `expired` pulse →
  - `tone_en` pattern 1111 00 1111 000000 1111 00 1111 (26 cycles);
  - `tone_rst` pulses on cycles 1, 7, 17 and 23;
  - `done` pulses once, coincident with `alarm_active` falling.
- **Stop mid-beep:** `stop` on the 2nd cycle of beep 3 → `tone_en`, `alarm_active` = 0 next cycle, `done` never asserts, and the block stays in IDLE with `expired` low.
- **Stop at terminal count:** `stop` high on the last ON cycle of the final beep → IDLE with `done` = 0.
- **Expired while active:** re-pulse `expired` during PAUSE → the pattern is unchanged (26 cycles total) and there is no extra `tone_rst`.
- **Held expired and simultaneous inputs:** hold `expired` high through completion → a second pattern starts 1 cycle after `done`. `expired` and `stop` high together in IDLE → no start.
